mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle MIPS control FSM. It is the issuing end of the ALU interface: it decodes opcode/funct into a per-cycle ALUop, operand-select and write-enable sequence, and it consumes the ALU Zero flag for beq.
- It replaces the single-cycle combinational controller in the multi-cycle datapath. The datapath contains IR, A/B, ALUOut and MDR registers.
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr.

Parameters:
- RA_IDX, 5'd31, register index written by jal. Fed to the datapath RegDst mux as selection 2.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-low reset. reset==0 at a clk edge resets the FSM.
- opcode  in  6  IR[31:26], valid from DECODE onward.
- funct  in  6  IR[5:0].
- Zero  in  1  ALU equality flag (A==B).
- ALUop  out  3  ADD=000, SUB=001, AND=010, OR=011, LUI=100.
- ALUSrcA  out  1  0=PC, 1=A register.
- ALUSrcB  out  2  0=B register, 1=constant 4, 2=ext(imm), 3=ext(imm)<<2.
- ExtOp  out  1  1=sign-extend imm, 0=zero-extend.
- IRWrite  out  1  IR load enable.
- PCWrite  out  1  PC load enable.
- PCSource  out  2  0=ALU result, 1=ALUOut, 2={PC[31:28],imm26,2'b00}, 3=A register.
- MemWrite  out  1  data memory write enable.
- RegWrite  out  1  GPR write enable.
- RegDst  out  2  0=rt, 1=rd, 2=RA_IDX.
- MemtoReg  out  2  0=ALUOut, 1=MDR, 2=PC.
- state  out  4  current state encoding, for debug and the bench.
- retire  out  1  one-cycle pulse in the final state of each instruction.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, EXE_R=2, EXE_I=3, MEM_ADR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JUMP=9, WB_R=10, WB_I=11.
  - Codes 12-15 are unreachable. If ever entered, go to FETCH next cycle with all enables 0.
- Outputs are decoded from state (Moore) except BRANCH PCWrite, which equals Zero (Mealy). Any enable not listed for a state is 0.
- FETCH:
  - Drives IRWrite=1, ALUSrcA=0, ALUSrcB=1, ALUop=ADD, PCWrite=1, PCSource=0.
  - Next state: DECODE.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=3, ALUop=ADD, ExtOp=1. This precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 000000 with funct 100001/100011 → EXE_R.
    - 000000 with funct 001000 → JUMP.
    - 001101/001111 → EXE_I.
    - 100011/101011 → MEM_ADR.
    - 000100 → BRANCH.
    - 000010/000011 → JUMP.
    - Anything else → FETCH. Treated as a nop: no register or memory write, retire=1.
- EXE_R:
  - Drives ALUSrcA=1, ALUSrcB=0, ALUop=ADD (addu) or SUB (subu).
  - Next state: WB_R.
- WB_R: RegWrite=1, RegDst=1, MemtoReg=0, retire=1. Next state: FETCH.
- EXE_I:
  - Drives ALUSrcA=1, ALUSrcB=2, ExtOp=0, ALUop=OR (ori) or LUI (lui).
  - Next state: WB_I.
- WB_I: RegWrite=1, RegDst=0, MemtoReg=0, retire=1. Next state: FETCH.
- MEM_ADR:
  - Drives ALUSrcA=1, ALUSrcB=2, ExtOp=1, ALUop=ADD.
  - Next state: MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: all enables 0. Next state: MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1, retire=1. Next state: FETCH.
- MEM_WR: MemWrite=1, retire=1. Next state: FETCH.
- BRANCH:
  - Drives ALUSrcA=1, ALUSrcB=0, ALUop=SUB, PCSource=1, PCWrite=Zero, retire=1.
  - Next state: FETCH.
- JUMP:
  - Drives PCWrite=1, retire=1. PCSource=3 for jr, otherwise 2.
  - For jal, also RegWrite=1, RegDst=2, MemtoReg=2 (PC already holds PC+4).
  - Next state: FETCH.
- Per-instruction cycle counts:
  - lw: 5.
  - addu, subu, ori, lui, sw: 4.
  - beq, j, jal, jr: 3.
  - Undefined opcode: 2.
- Reset:
  - While reset==0, all write enables (IRWrite, PCWrite, MemWrite, RegWrite) and retire are forced to 0 combinationally.
  - The edge with reset==0 loads state=FETCH.
  - Reset asserted mid-instruction (any state) abandons that instruction. No partial write is issued in the reset cycle.
- opcode/funct are sampled only in DECODE, EXE_R, EXE_I, MEM_ADR and JUMP. IR is stable across these states, so no input registering is required.

Test Plan:
- Reset held low 2 cycles, then released → state=0, all enables 0 while low; next cycle state=1 with IRWrite/PCWrite having pulsed in FETCH.
- addu (op 000000, funct 100001) → states 0,1,2,10,0; ALUop=000 in EXE_R; RegWrite=1 with RegDst=1 in WB_R; retire is high exactly one cycle.
- lw (100011) then sw (101011) → lw: 0,1,4,5,6 with MemtoReg=1 in MEM_WB; sw: 0,1,4,7 with MemWrite=1 once and RegWrite never set.
- beq (000100) with Zero=1, then with Zero=0 → BRANCH PCWrite=1 and PCSource=1 in the first case; PCWrite=0 in the second; ALUop=001 in both.
- jal (000011) and jr (000000/001000) → jal: JUMP with PCSource=2, RegWrite=1, RegDst=2, MemtoReg=2; jr: PCSource=3, RegWrite=0.
- Illegal opcode 111111, then reset asserted while in MEM_RD → illegal op: DECODE→FETCH with no writes; reset case: state=0 next cycle and RegWrite never asserted.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multi-cycle MIPS controller (master) and its datapath (slave).
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       Zero;
    logic [2:0] ALUop;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic [3:0] state;
    logic       retire;

    modport master (
        input  opcode, funct, Zero,
        output ALUop, ALUSrcA, ALUSrcB, ExtOp, IRWrite, PCWrite, PCSource,
               MemWrite, RegWrite, RegDst, MemtoReg, state, retire
    );

    modport slave (
        output opcode, funct, Zero,
        input  ALUop, ALUSrcA, ALUSrcB, ExtOp, IRWrite, PCWrite, PCSource,
               MemWrite, RegWrite, RegDst, MemtoReg, state, retire
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: Moore decode of datapath controls per state,
// with the BRANCH PC write taken directly from the ALU Zero flag.
module mc_ctrl #(
    parameter logic [4:0] RA_IDX = 5'd31
) (
    input  logic      clk,
    input  logic      reset,
    mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        EXE_R   = 4'd2,
        EXE_I   = 4'd3,
        MEM_ADR = 4'd4,
        MEM_RD  = 4'd5,
        MEM_WB  = 4'd6,
        MEM_WR  = 4'd7,
        BRANCH  = 4'd8,
        JUMP    = 4'd9,
        WB_R    = 4'd10,
        WB_I    = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_LUI = 3'b100;

    // jal writes through RegDst selection 2; index 0 would silently discard the link.
    if (RA_IDX == 5'd0) begin : g_ra_idx_check
        $error("mc_ctrl: RA_IDX must not be register 0");
    end

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = FETCH;
        bus.ALUop    = ALU_ADD;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'd0;
        bus.ExtOp    = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.PCSource = 2'd0;
        bus.MemWrite = 1'b0;
        bus.RegWrite = 1'b0;
        bus.RegDst   = 2'd0;
        bus.MemtoReg = 2'd0;
        bus.retire   = 1'b0;

        case (state_q)
            FETCH: begin
                bus.IRWrite = 1'b1;
                bus.ALUSrcB = 2'd1;
                bus.PCWrite = 1'b1;
                state_d     = DECODE;
            end
            DECODE: begin
                bus.ALUSrcB = 2'd3;
                bus.ExtOp   = 1'b1;
                case (bus.opcode)
                    OP_RTYPE: begin
                        if (bus.funct == FN_ADDU || bus.funct == FN_SUBU) state_d = EXE_R;
                        else if (bus.funct == FN_JR)                      state_d = JUMP;
                        else                                              bus.retire = 1'b1;
                    end
                    OP_ORI, OP_LUI: state_d = EXE_I;
                    OP_LW, OP_SW:   state_d = MEM_ADR;
                    OP_BEQ:         state_d = BRANCH;
                    OP_J, OP_JAL:   state_d = JUMP;
                    default:        bus.retire = 1'b1;
                endcase
            end
            EXE_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUop   = (bus.funct == FN_SUBU) ? ALU_SUB : ALU_ADD;
                state_d     = WB_R;
            end
            WB_R: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 2'd1;
                bus.retire   = 1'b1;
            end
            EXE_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                bus.ALUop   = (bus.opcode == OP_LUI) ? ALU_LUI : ALU_OR;
                state_d     = WB_I;
            end
            WB_I: begin
                bus.RegWrite = 1'b1;
                bus.retire   = 1'b1;
            end
            MEM_ADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'd2;
                bus.ExtOp   = 1'b1;
                if (bus.opcode == OP_LW)      state_d = MEM_RD;
                else if (bus.opcode == OP_SW) state_d = MEM_WR;
            end
            MEM_RD: state_d = MEM_WB;
            MEM_WB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 2'd1;
                bus.retire   = 1'b1;
            end
            MEM_WR: begin
                bus.MemWrite = 1'b1;
                bus.retire   = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUop    = ALU_SUB;
                bus.PCSource = 2'd1;
                bus.PCWrite  = bus.Zero;
                bus.retire   = 1'b1;
            end
            JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.retire   = 1'b1;
                bus.PCSource = (bus.opcode == OP_RTYPE) ? 2'd3 : 2'd2;
                if (bus.opcode == OP_JAL) begin
                    bus.RegWrite = 1'b1;
                    bus.RegDst   = 2'd2;
                    bus.MemtoReg = 2'd2;
                end
            end
            default: state_d = FETCH;
        endcase

        // Reset masks every write so an abandoned instruction leaves no partial update.
        if (!reset) begin
            bus.IRWrite  = 1'b0;
            bus.PCWrite  = 1'b0;
            bus.MemWrite = 1'b0;
            bus.RegWrite = 1'b0;
            bus.retire   = 1'b0;
        end
    end

    assign bus.state = state_q;
endmodule
